tlc_phase_scheduler: RTL and testbench

Round-robin phase scheduler that sits between the raw intersection sensors and the traffic-light sequencer. It latches transient vehicle requests for the five signal phases and picks one phase at a time, with age-based priority. It offers that phase to the sequencer over a valid/ready handshake, then waits for the sequencer to report the phase finished (through yellow and all-red) before offering the next one.

---
 rtl/tlc_phase_scheduler.sv | 92 +++++++++
 tb/tb_tlc_phase_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: age-aware round-robin phase arbiter with valid/ready offer and phase_done completion.
// Define TLC_EMERG_PREEMPT_EN to add the emerg input (forces NS) and the preempt output.
module tlc_phase_scheduler #(
  parameter int NPH = 5,
  parameter int AGE_W = 4,
  parameter int AGE_LIMIT = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NPH-1:0] sensor,
  input  logic           grant_ready,
  input  logic           phase_done,
`ifdef TLC_EMERG_PREEMPT_EN
  input  logic           emerg,
  output logic           preempt,
`endif
  output logic           grant_valid,
  output logic [NPH-1:0] grant,
  output logic [NPH-1:0] pending,
  output logic           busy
);
  localparam int PW = $clog2(NPH);
  typedef enum logic [1:0] {IDLE, OFFER, ACTIVE} state_t;
  state_t state, state_n;
  logic [AGE_W-1:0] age [NPH];
  logic [PW-1:0] ptr, ptr_n, idx, gidx;
  logic [NPH-1:0] grant_n, pend_n, win, aged, cand, em;
  logic hs;
`ifdef TLC_EMERG_PREEMPT_EN
  assign em = {emerg, {(NPH-1){1'b0}}};
`else
  assign em = '0;
`endif
  assign grant_valid = state == OFFER;
  assign busy = state == ACTIVE;
  assign hs = state == OFFER && grant_ready;
  assign pend_n = (pending | sensor | em) & ~(hs ? grant : '0);
  // Aged requests take precedence; either way scan upward from ptr with wrap.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = 0; i < NPH; i++) aged[i] = pending[i] && age[i] >= AGE_W'(AGE_LIMIT);
    cand = |aged ? aged : pending;
    for (int j = NPH - 1; j >= 0; j--) begin
      idx = PW'((int'(ptr) + j) % NPH);
      if (cand[idx]) begin
        win = '0;
        win[idx] = 1'b1;
      end
    end
    if (|em) win = em;
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    gidx = '0;
    for (int i = 0; i < NPH; i++) if (grant[i]) gidx = PW'(i);
    ptr_n = hs ? (gidx == PW'(NPH - 1) ? '0 : gidx + 1'b1) : ptr;
    if (state == IDLE && |pending) begin
      state_n = OFFER;
      grant_n = win;
    end
    if (hs) state_n = ACTIVE;
    if (state == ACTIVE && phase_done) begin
      state_n = IDLE;
      grant_n = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      pending <= '0;
      ptr <= '0;
      for (int i = 0; i < NPH; i++) age[i] <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      pending <= pend_n;
      ptr <= ptr_n;
      for (int i = 0; i < NPH; i++)
        age[i] <= (!pending[i] || (hs && grant[i])) ? '0 : age[i] + {{(AGE_W-1){1'b0}}, ~&age[i]};
    end
  end
`ifdef TLC_EMERG_PREEMPT_EN
  // Early-yellow request for a non-NS phase; dropped once the phase completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) preempt <= 1'b0;
    else preempt <= state == ACTIVE && !phase_done && !grant[NPH-1] && (emerg || preempt);
  end
`endif
endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb_tlc_phase_scheduler: directed checks of latching, handshake, round-robin, ageing and reset behaviour.
module tb_tlc_phase_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] sensor = '0;
  logic grant_ready = 1'b0;
  logic phase_done = 1'b0;
  logic grant_valid, busy;
  logic [4:0] grant, pending;
  int total = 0;
  int bad = 0;
`ifdef TLC_EMERG_PREEMPT_EN
  logic emerg = 1'b0;
  logic preempt;
`endif
  tlc_phase_scheduler dut (
    .clk(clk),
    .reset(reset),
    .sensor(sensor),
    .grant_ready(grant_ready),
    .phase_done(phase_done),
`ifdef TLC_EMERG_PREEMPT_EN
    .emerg(emerg),
    .preempt(preempt),
`endif
    .grant_valid(grant_valid),
    .grant(grant),
    .pending(pending),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask
  logic [4:0] exp_rr [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
  initial begin
    tick;
    reset = 1'b0;
    check("rst_valid", grant_valid, 0);
    check("rst_grant", grant, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    phase_done = 1'b1;
    grant_ready = 1'b1;
    tick;
    phase_done = 1'b0;
    grant_ready = 1'b0;
    check("idle_done_busy", busy, 0);
    check("idle_done_valid", grant_valid, 0);
    check("idle_done_grant", grant, 0);
    sensor = 5'b00100;
    tick;
    sensor = '0;
    check("pulse_pending", pending, 5'b00100);
    check("pulse_valid0", grant_valid, 0);
    tick;
    check("offer_valid", grant_valid, 1);
    check("offer_grant", grant, 5'b00100);
    for (int i = 0; i < 5; i++) begin
      phase_done = i == 2;
      tick;
      check("hold_valid", grant_valid, 1);
      check("hold_grant", grant, 5'b00100);
      check("hold_busy", busy, 0);
    end
    phase_done = 1'b0;
    grant_ready = 1'b1;
    tick;
    grant_ready = 1'b0;
    check("hs_busy", busy, 1);
    check("hs_valid", grant_valid, 0);
    check("hs_pending", pending, 0);
    check("hs_grant", grant, 5'b00100);
    repeat (2) tick;
    check("active_hold", grant, 5'b00100);
    reset = 1'b1;
    #1;
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", grant_valid, 0);
    tick;
    reset = 1'b0;
    repeat (3) tick;
    check("postrst_valid", grant_valid, 0);
    check("postrst_grant", grant, 0);
    // round-robin with every sensor held
    sensor = 5'b11111;
    grant_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      while (!busy && n < 20) begin
        tick;
        n++;
      end
      check("rr_busy", busy, 1);
      check("rr_grant", grant, exp_rr[k]);
      repeat (2) tick;
      phase_done = 1'b1;
      tick;
      phase_done = 1'b0;
    end
    sensor = '0;
    grant_ready = 1'b0;
    // ageing: phase 0 aged beats phase 3 despite ptr=1
    do_reset;
    sensor = 5'b00001;
    tick;
    sensor = '0;
    tick;
    grant_ready = 1'b1;
    tick;
    grant_ready = 1'b0;
    check("age_ptr_start", dut.ptr, 1);
    sensor = 5'b00001;
    tick;
    sensor = '0;
    repeat (12) tick;
    sensor = 5'b01000;
    tick;
    sensor = '0;
    phase_done = 1'b1;
    tick;
    phase_done = 1'b0;
    check("age_pending", pending, 5'b01001);
    tick;
    check("age_grant", grant, 5'b00001);
    check("age_valid", grant_valid, 1);
    grant_ready = 1'b1;
    tick;
    grant_ready = 1'b0;
    check("age_ptr", dut.ptr, 1);
    check("age_left", pending, 5'b01000);
    phase_done = 1'b1;
    tick;
    phase_done = 1'b0;
    tick;
    check("age_next", grant, 5'b01000);
    // clear wins over simultaneous sensor on handshake
    do_reset;
    sensor = 5'b00010;
    tick;
    tick;
    check("coll_offer", grant, 5'b00010);
    grant_ready = 1'b1;
    tick;
    grant_ready = 1'b0;
    check("coll_clear", pending, 0);
    tick;
    sensor = '0;
    check("coll_reset", pending, 5'b00010);
`ifdef TLC_EMERG_PREEMPT_EN
    do_reset;
    sensor = 5'b00011;
    tick;
    sensor = '0;
    tick;
    grant_ready = 1'b1;
    tick;
    grant_ready = 1'b0;
    check("em_grant0", grant, 5'b00001);
    check("em_pre0", preempt, 0);
    emerg = 1'b1;
    tick;
    check("em_preempt", preempt, 1);
    check("em_pend4", pending[4], 1);
    tick;
    check("em_hold", preempt, 1);
    phase_done = 1'b1;
    tick;
    phase_done = 1'b0;
    check("em_drop", preempt, 0);
    tick;
    emerg = 1'b0;
    check("em_offer", grant, 5'b10000);
    check("em_valid", grant_valid, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
